// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX checksum stream checker.
package fix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } fix_state_e;

    localparam logic [7:0]  SOH         = 8'h01;
    localparam logic [7:0]  ASCII_0     = 8'h30;
    localparam logic [7:0]  ASCII_1     = 8'h31;
    localparam logic [7:0]  ASCII_9     = 8'h39;
    localparam logic [7:0]  ASCII_EQ    = 8'h3D;
    localparam int unsigned TRAILER_LEN = 7;
    localparam int unsigned HIST_W      = 8 * TRAILER_LEN;

    // True when c is an ASCII decimal digit.
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/fix_lane_sum.sv
// Modulo-256 sum of the kept byte lanes of one beat.
module fix_lane_sum #(
    parameter int unsigned BYTES = 1
) (
    input  logic [8*BYTES-1:0] data,
    input  logic [BYTES-1:0]   keep,
    output logic [7:0]         sum_c
);

    // Add every kept lane; the 8-bit accumulator wraps naturally.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (keep[i]) begin
                sum_c = sum_c + data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/fix_checksum_stream.sv
// FIX message checksum checker: sums the message body, decodes the
// "10=ddd<SOH>" trailer and reports the comparison once per message.
// Optional statistics counters are built when FIX_CHECKSUM_STATS_EN is defined.
module fix_checksum_stream
    import fix_pkg::*;
#(
    parameter int unsigned BYTES = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [8*BYTES-1:0] data_i,
    input  logic [BYTES-1:0]   keep_i,
    input  logic               valid_i,
    input  logic               sop_i,
    input  logic               eop_i,
    output logic               done_o,
    output logic [7:0]         checksum_o,
    output logic [7:0]         rx_checksum_o,
    output logic               match_o,
    output logic               format_err_o,
    output logic [CNT_W-1:0]   good_cnt_o,
    output logic [CNT_W-1:0]   bad_cnt_o
);

    fix_state_e        state, state_nxt;
    logic [7:0]        sum_q;
    logic [HIST_W-1:0] hist_q;
    logic [2:0]        cnt_q;

    logic              take_c, load_c;
    logic [7:0]        lane_sum_c, sum_nxt_c, hist_sum_c, checksum_c, rx_c;
    logic [HIST_W-1:0] hist_nxt_c;
    logic [2:0]        cnt_nxt_c;
    logic [9:0]        dec_c;
    logic              fmt_err_c, match_c;

    fix_lane_sum #(.BYTES(BYTES)) u_lane_sum (
        .data  (data_i),
        .keep  (keep_i),
        .sum_c (lane_sum_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a sop beat always (re)starts a message.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_REPORT: begin
                state_nxt = ST_IDLE;
                if (valid_i && sop_i) state_nxt = eop_i ? ST_REPORT : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (valid_i && eop_i) state_nxt = ST_REPORT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Beat acceptance and result-load strobes.
    always_comb begin
        take_c = 1'b0;
        load_c = 1'b0;
        if (valid_i && (sop_i || (state == ST_ACCUM))) begin
            take_c = 1'b1;
            load_c = eop_i;
        end
    end

    // Running sum, history shift and trailer decode for the current beat.
    always_comb begin
        sum_nxt_c  = sop_i ? lane_sum_c : 8'(sum_q + lane_sum_c);
        hist_nxt_c = sop_i ? '0 : hist_q;
        cnt_nxt_c  = sop_i ? 3'd0 : cnt_q;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (keep_i[i]) begin
                hist_nxt_c = {hist_nxt_c[HIST_W-9:0], data_i[8*i +: 8]};
                if (cnt_nxt_c < 3'(TRAILER_LEN)) cnt_nxt_c = cnt_nxt_c + 3'd1;
            end
        end
        hist_sum_c = '0;
        for (int unsigned j = 0; j < TRAILER_LEN; j++) begin
            hist_sum_c = hist_sum_c + hist_nxt_c[8*j +: 8];
        end
        checksum_c = 8'(sum_nxt_c - hist_sum_c);
        dec_c = 10'(hist_nxt_c[27:24]) * 10'd100 +
                10'(hist_nxt_c[19:16]) * 10'd10 +
                10'(hist_nxt_c[11:8]);
        rx_c = dec_c[7:0];
        fmt_err_c = (cnt_nxt_c < 3'(TRAILER_LEN))  ||
                    (hist_nxt_c[55:48] != ASCII_1)  ||
                    (hist_nxt_c[47:40] != ASCII_0)  ||
                    (hist_nxt_c[39:32] != ASCII_EQ) ||
                    !is_digit(hist_nxt_c[31:24])    ||
                    !is_digit(hist_nxt_c[23:16])    ||
                    !is_digit(hist_nxt_c[15:8])     ||
                    (hist_nxt_c[7:0] != SOH)        ||
                    (dec_c > 10'd255);
        match_c = !fmt_err_c && (checksum_c == rx_c);
    end

    // Accumulators advance on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            hist_q <= '0;
            cnt_q  <= '0;
        end else if (take_c) begin
            sum_q  <= sum_nxt_c;
            hist_q <= hist_nxt_c;
            cnt_q  <= cnt_nxt_c;
        end
    end

    // Result registers load on the eop beat and hold until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_o        <= 1'b0;
            checksum_o    <= '0;
            rx_checksum_o <= '0;
            match_o       <= 1'b0;
            format_err_o  <= 1'b0;
        end else begin
            done_o <= load_c;
            if (load_c) begin
                checksum_o    <= checksum_c;
                rx_checksum_o <= rx_c;
                match_o       <= match_c;
                format_err_o  <= fmt_err_c;
            end
        end
    end

`ifdef FIX_CHECKSUM_STATS_EN
    // Saturating good/bad message counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt_o <= '0;
            bad_cnt_o  <= '0;
        end else if (done_o) begin
            if (match_o) begin
                if (good_cnt_o != '1) good_cnt_o <= good_cnt_o + 1'b1;
            end else begin
                if (bad_cnt_o != '1) bad_cnt_o <= bad_cnt_o + 1'b1;
            end
        end
    end
`else
    assign good_cnt_o = '0;
    assign bad_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_fix_checksum_stream.sv
// Bench for fix_checksum_stream: one BYTES=1 and one BYTES=4 instance,
// table-driven messages with a scoreboard queue per instance.
module tb_fix_checksum_stream;

    typedef struct {
        logic [7:0] b [16];
        int         len;
        logic [7:0] cks;
        logic [7:0] rx;
        logic       m;
        logic       f;
        bit         crx;
        bit         ccks;
        bit         wide_ok;
    } vec_t;

    typedef struct {
        logic [7:0] cks;
        logic [7:0] rx;
        logic       m;
        logic       f;
        bit         crx;
        bit         ccks;
        int         stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        v1 = 0, s1 = 0, e1 = 0;
    logic [7:0]  d1 = '0;
    logic [0:0]  k1 = '0;
    logic        v4 = 0, s4 = 0, e4 = 0;
    logic [31:0] d4 = '0;
    logic [3:0]  k4 = '0;

    logic        done1, m1, f1, done4, m4, f4;
    logic [7:0]  c1, r1, c4, r4;
    logic [15:0] g1, bd1, g4, bd4;

    exp_t q1[$];
    exp_t q4[$];
    int   good1 = 0, bad1 = 0, good4 = 0, bad4 = 0;
    vec_t vt [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fix_checksum_stream #(.BYTES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .data_i(d1), .keep_i(k1), .valid_i(v1),
        .sop_i(s1), .eop_i(e1), .done_o(done1), .checksum_o(c1),
        .rx_checksum_o(r1), .match_o(m1), .format_err_o(f1),
        .good_cnt_o(g1), .bad_cnt_o(bd1)
    );

    fix_checksum_stream #(.BYTES(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .data_i(d4), .keep_i(k4), .valid_i(v4),
        .sop_i(s4), .eop_i(e4), .done_o(done4), .checksum_o(c4),
        .rx_checksum_o(r4), .match_o(m4), .format_err_o(f4),
        .good_cnt_o(g4), .bad_cnt_o(bd4)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // '|' stands for SOH (0x01) and '#' for 0xFF; everything else is ASCII.
    function automatic vec_t mkv(input string s, input logic [7:0] cks, input logic [7:0] rx,
                                 input logic m, input logic f, input bit crx, input bit ccks,
                                 input bit wide_ok);
        vec_t v;
        for (int i = 0; i < 16; i++) v.b[i] = 8'h00;
        v.len = s.len();
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "|")      v.b[i] = 8'h01;
            else if (s[i] == "#") v.b[i] = 8'hFF;
            else                  v.b[i] = s[i];
        end
        v.cks = cks; v.rx = rx; v.m = m; v.f = f;
        v.crx = crx; v.ccks = ccks; v.wide_ok = wide_ok;
        return v;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v1 = 0; s1 = 0; e1 = 0; k1 = '0;
            v4 = 0; s4 = 0; e4 = 0; k4 = '0;
        end
    endtask

    // Drive a message on one instance (d=0: BYTES=1, d=1: BYTES=4); no trailing idle.
    task automatic send(input int d, input vec_t v, input bit do_eop, input bit push);
        int          lanes;
        logic [31:0] dat;
        logic [3:0]  kp;
        bit          last;
        exp_t        e;
        lanes = (d == 0) ? 1 : 4;
        for (int p = 0; p < v.len; p += lanes) begin
            @(negedge clk);
            dat = '0; kp = '0;
            for (int l = 0; l < lanes; l++) begin
                if (p + l < v.len) begin
                    dat[8*l +: 8] = v.b[p+l];
                    kp[l] = 1'b1;
                end
            end
            last = (p + lanes >= v.len);
            if (d == 0) begin
                v1 = 1; d1 = dat[7:0]; k1 = kp[0:0]; s1 = (p == 0); e1 = do_eop && last;
            end else begin
                v4 = 1; d4 = dat; k4 = kp; s4 = (p == 0); e4 = do_eop && last;
            end
            if (do_eop && last && push) begin
                e.cks = v.cks; e.rx = v.rx; e.m = v.m; e.f = v.f;
                e.crx = v.crx; e.ccks = v.ccks; e.stamp = cyc;
                if (d == 0) begin
                    q1.push_back(e);
                    if (v.m) good1++; else bad1++;
                end else begin
                    q4.push_back(e);
                    if (v.m) good4++; else bad4++;
                end
            end
        end
    endtask

    task automatic cmp_res(input string p, input exp_t e, input logic [7:0] c,
                           input logic [7:0] r, input logic m, input logic f);
        chk({p, "_latency"}, cyc - e.stamp, 1);
        if (e.ccks) chk({p, "_checksum"}, int'(c), int'(e.cks));
        if (e.crx)  chk({p, "_rx"}, int'(r), int'(e.rx));
        chk({p, "_match"}, int'(m), int'(e.m));
        chk({p, "_fmt_err"}, int'(f), int'(e.f));
    endtask

    task automatic chk_reset_outputs(input string p, input logic dn, input logic [7:0] c,
                                     input logic [7:0] r, input logic m, input logic f,
                                     input logic [15:0] g, input logic [15:0] b);
        chk({p, "_rst_done"}, int'(dn), 0);
        chk({p, "_rst_cks"}, int'(c), 0);
        chk({p, "_rst_rx"}, int'(r), 0);
        chk({p, "_rst_match"}, int'(m), 0);
        chk({p, "_rst_ferr"}, int'(f), 0);
        chk({p, "_rst_good"}, int'(g), 0);
        chk({p, "_rst_bad"}, int'(b), 0);
    endtask

    initial begin
        vt[0]  = mkv("A|10=066|",   8'h42, 8'h42, 1, 0, 1, 1, 1);
        vt[1]  = mkv("A|10=067|",   8'h42, 8'h43, 0, 0, 1, 1, 1);
        vt[2]  = mkv("##|10=255|",  8'hFF, 8'hFF, 1, 0, 1, 1, 1);
        vt[3]  = mkv("A|11=066|",   8'h42, 8'h42, 0, 1, 1, 1, 1);
        vt[4]  = mkv("A|10=999|",   8'h42, 8'hE7, 0, 1, 1, 1, 1);
        vt[5]  = mkv("8=A|10=183|", 8'hB7, 8'hB7, 1, 0, 1, 1, 1);
        vt[6]  = mkv("10=000|",     8'h00, 8'h00, 1, 0, 1, 1, 1);
        vt[7]  = mkv("10=0A6|",     8'h00, 8'h00, 0, 1, 0, 1, 1);
        vt[8]  = mkv("A|10=066=",   8'h42, 8'h42, 0, 1, 1, 1, 1);
        vt[9]  = mkv("8=|",         8'h00, 8'h00, 0, 1, 0, 0, 0);
        vt[10] = mkv("01|10=098|",  8'h62, 8'h62, 1, 0, 1, 1, 1);
        vt[11] = mkv("A|10=256|",   8'h42, 8'h00, 0, 1, 1, 1, 1);

        // Scoreboard monitor: every done_o must match the oldest expected result.
        fork
            forever begin
                @(negedge clk);
                if (done1) begin
                    if (q1.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL dut1_spurious_done: got done_o=1 expected no result (cycle %0d)", cyc);
                    end else cmp_res("dut1", q1.pop_front(), c1, r1, m1, f1);
                end
                if (done4) begin
                    if (q4.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL dut4_spurious_done: got done_o=1 expected no result (cycle %0d)", cyc);
                    end else cmp_res("dut4", q4.pop_front(), c4, r4, m4, f4);
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk_reset_outputs("dut1", done1, c1, r1, m1, f1, g1, bd1);
        chk_reset_outputs("dut4", done4, c4, r4, m4, f4, g4, bd4);

        // Reset mid-message: partial message vanishes, next one is reported.
        send(0, vt[5], 0, 0);
        send(1, vt[5], 0, 0);
        @(negedge clk);
        rst = 1; v1 = 0; v4 = 0;
        @(negedge clk);
        rst = 0;
        good1 = 0; bad1 = 0; good4 = 0; bad4 = 0;
        idle(2);
        send(0, vt[0], 1, 1);
        idle(3);
        send(1, vt[0], 1, 1);
        idle(3);

        // sop mid-message aborts the partial message.
        send(0, vt[5], 0, 0);
        send(0, vt[1], 1, 1);
        idle(3);
        send(1, vt[5], 0, 0);
        send(1, vt[10], 1, 1);
        idle(3);

        // Table of messages on both lane widths.
        for (int i = 0; i < 12; i++) begin
            send(0, vt[i], 1, 1);
            idle(3);
            if (vt[i].ccks) chk($sformatf("dut1_hold_cks_%0d", i), int'(c1), int'(vt[i].cks));
            if (vt[i].wide_ok) begin
                send(1, vt[i], 1, 1);
                idle(3);
            end
        end

        // Back-to-back: sop arrives in the REPORT cycle of the previous message.
        send(1, vt[10], 1, 1);
        send(1, vt[5], 1, 1);
        send(1, vt[1], 1, 1);
        idle(3);
        send(0, vt[0], 1, 1);
        send(0, vt[2], 1, 1);
        idle(4);

        chk("dut1_results_drained", q1.size(), 0);
        chk("dut4_results_drained", q4.size(), 0);
`ifdef FIX_CHECKSUM_STATS_EN
        chk("dut1_good_cnt", int'(g1), good1);
        chk("dut1_bad_cnt", int'(bd1), bad1);
        chk("dut4_good_cnt", int'(g4), good4);
        chk("dut4_bad_cnt", int'(bd4), bad4);
`else
        chk("dut1_good_cnt", int'(g1), 0);
        chk("dut1_bad_cnt", int'(bd1), 0);
        chk("dut4_good_cnt", int'(g4), 0);
        chk("dut4_bad_cnt", int'(bd4), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
